// File: rtl/ascon_perm_scheduler.sv
// ascon_perm_scheduler
// Shares one single-round, combinational ASCON permutation core between two
// requesters. Jobs are granted round-robin and the round function is iterated
// N times on the captured state. The result is returned on a valid/ready
// channel, tagged with the ID of the requester that owns it.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s0_* / s1_*                  requester job channels (valid/ready, state, round count)
//   rf_state_in, rf_round        state and round index driven into the round core
//   rf_state_out                 combinational round-core result
//   m_valid/m_ready/m_state/m_id result channel
//   busy                         high while a job is running or its result is pending
//   job_count                    completed-job counter (wraps)
module ascon_perm_scheduler #(
  parameter int unsigned STATE_W    = 128,
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic [STATE_W-1:0] s0_state,
  input  logic [3:0]         s0_rounds,
  input  logic               s1_valid,
  output logic               s1_ready,
  input  logic [STATE_W-1:0] s1_state,
  input  logic [3:0]         s1_rounds,
  output logic [STATE_W-1:0] rf_state_in,
  output logic [3:0]         rf_round,
  input  logic [STATE_W-1:0] rf_state_out,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [STATE_W-1:0] m_state,
  output logic               m_id,
  output logic               busy,
  output logic [15:0]        job_count
);

  localparam int unsigned RND_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e               fsm_q;
  logic [STATE_W-1:0] state_q;
  logic [RND_W-1:0]   start_q;
  logic [RND_W-1:0]   cnt_q;
  logic [RND_W-1:0]   n_q;
  logic               last_grant_q;

  logic               in_idle;
  logic               grant_vld;
  logic               grant_id;
  logic               accept;
  logic [STATE_W-1:0] sel_state;
  logic [RND_W-1:0]   sel_rounds;
  logic [RND_W-1:0]   n_clamp;

  // Round-robin grant: a tie goes to the requester not served last.
  always_comb begin
    in_idle    = (fsm_q == IDLE);
    grant_vld  = s0_valid | s1_valid;
    grant_id   = (s0_valid & s1_valid) ? ~last_grant_q : s1_valid;
    sel_state  = grant_id ? s1_state  : s0_state;
    sel_rounds = grant_id ? s1_rounds : s0_rounds;
    // A zero or out-of-range round count means a full permutation.
    if ((sel_rounds == '0) || (sel_rounds > RND_W'(MAX_ROUNDS))) begin
      n_clamp = RND_W'(MAX_ROUNDS);
    end else begin
      n_clamp = sel_rounds;
    end
    accept   = in_idle & grant_vld;
    s0_ready = accept & ~grant_id;
    s1_ready = accept &  grant_id;
  end

  // Core drive: the round index is only meaningful in RUN.
  always_comb begin
    rf_state_in = state_q;
    rf_round    = (fsm_q == RUN) ? RND_W'(start_q + cnt_q) : '0;
    busy        = (fsm_q != IDLE);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      state_q      <= '0;
      start_q      <= '0;
      cnt_q        <= '0;
      n_q          <= '0;
      last_grant_q <= 1'b1;
      m_valid      <= 1'b0;
      m_state      <= '0;
      m_id         <= 1'b0;
      job_count    <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (accept) begin
            state_q      <= sel_state;
            n_q          <= n_clamp;
            start_q      <= RND_W'(RND_W'(MAX_ROUNDS) - n_clamp);
            cnt_q        <= '0;
            m_id         <= grant_id;
            last_grant_q <= grant_id;
            fsm_q        <= RUN;
          end
        end
        RUN: begin
          state_q <= rf_state_out;
          cnt_q   <= RND_W'(cnt_q + RND_W'(1));
          // This edge applies the final round.
          if (cnt_q == RND_W'(n_q - RND_W'(1))) begin
            m_state <= rf_state_out;
            m_valid <= 1'b1;
            fsm_q   <= DONE;
          end
        end
        DONE: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            job_count <= CNT_W'(job_count + CNT_W'(1));
            fsm_q     <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// Directed testbench for ascon_perm_scheduler, with a stub round core
// rf_state_out = rotl1(rf_state_in) ^ rf_round.
module tb_ascon_perm_scheduler;

  localparam int unsigned SW = 128;

  logic          clk;
  logic          rst;
  logic          s0_valid, s1_valid;
  logic          s0_ready, s1_ready;
  logic [SW-1:0] s0_state, s1_state;
  logic [3:0]    s0_rounds, s1_rounds;
  logic [SW-1:0] rf_state_in;
  logic [3:0]    rf_round;
  logic [SW-1:0] rf_state_out;
  logic          m_valid;
  logic          m_ready;
  logic [SW-1:0] m_state;
  logic          m_id;
  logic          busy;
  logic [15:0]   job_count;

  int n_cmp;
  int n_mis;
  int exp_jobs;

  localparam logic [SW-1:0] TOP_LOW = {1'b1, 126'd0, 1'b1};

  ascon_perm_scheduler #(.STATE_W(SW), .MAX_ROUNDS(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .s0_valid    (s0_valid),
    .s0_ready    (s0_ready),
    .s0_state    (s0_state),
    .s0_rounds   (s0_rounds),
    .s1_valid    (s1_valid),
    .s1_ready    (s1_ready),
    .s1_state    (s1_state),
    .s1_rounds   (s1_rounds),
    .rf_state_in (rf_state_in),
    .rf_round    (rf_round),
    .rf_state_out(rf_state_out),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_state     (m_state),
    .m_id        (m_id),
    .busy        (busy),
    .job_count   (job_count)
  );

  assign rf_state_out = {rf_state_in[SW-2:0], rf_state_in[SW-1]} ^ SW'(rf_round);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_jobs = 0;
  endtask

  // Runs one job from a single requester; entered and left just after a rising edge in IDLE.
  task automatic do_job(input bit id, input logic [SW-1:0] st, input logic [3:0] rnds,
                        input logic [SW-1:0] exp_st, input int n, input int hold);
    if (id) begin
      s1_valid = 1'b1; s1_state = st; s1_rounds = rnds;
    end else begin
      s0_valid = 1'b1; s0_state = st; s0_rounds = rnds;
    end
    m_ready = 1'b0;
    @(negedge clk);
    check("s0_ready_idle", SW'(s0_ready), SW'(!id));
    check("s1_ready_idle", SW'(s1_ready), SW'(id));
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("rf_round_run", SW'(rf_round), SW'(12 - n + k));
      check("m_valid_run", SW'(m_valid), SW'(0));
      check("busy_run", SW'(busy), SW'(1));
    end
    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      check("m_valid_done", SW'(m_valid), SW'(1));
      check("m_state_done", m_state, exp_st);
      check("m_id_done", SW'(m_id), SW'(id));
      check("ready_done", SW'({s0_ready, s1_ready}), SW'(0));
      check("jobs_held", SW'(job_count), SW'(exp_jobs));
      if (h < hold) @(negedge clk);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    exp_jobs++;
    check("job_count", SW'(job_count), SW'(exp_jobs));
    check("m_valid_clr", SW'(m_valid), SW'(0));
    check("busy_idle", SW'(busy), SW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_mis = 0; exp_jobs = 0;
    rst = 1'b0; m_ready = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_state = '0; s1_state = '0; s0_rounds = '0; s1_rounds = '0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_busy", SW'(busy), SW'(0));
    check("rst_m_valid", SW'(m_valid), SW'(0));
    check("rst_m_state", m_state, SW'(0));
    check("rst_m_id", SW'(m_id), SW'(0));
    check("rst_jobs", SW'(job_count), SW'(0));
    check("rst_rf_round", SW'(rf_round), SW'(0));
    check("rst_rf_state", rf_state_in, SW'(0));
    @(posedge clk); #1;

    // Single-round and two-round jobs: 0 -> 0x0B, 0 -> 0x0A -> 0x1F
    do_job(1'b0, SW'(0), 4'd1, SW'(128'h0B), 1, 0);
    do_job(1'b1, SW'(0), 4'd2, SW'(128'h1F), 2, 0);

    // Zero and out-of-range round counts run a full 12-round permutation (0 -> 0x8B)
    do_job(1'b0, SW'(0), 4'd0,  SW'(128'h8B), 12, 0);
    do_job(1'b0, SW'(0), 4'd15, SW'(128'h8B), 12, 0);

    // Back-pressure for 5 cycles; the bit-127 wrap gives 0x3 ^ 0xB = 0x8
    do_job(1'b1, TOP_LOW, 4'd1, SW'(128'h08), 1, 5);

    // Tie from reset alternates 0,1,0
    do_reset();
    s0_valid = 1'b1; s1_valid = 1'b1;
    s0_state = '0; s1_state = '0; s0_rounds = 4'd1; s1_rounds = 4'd1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("tie_s0_ready", SW'(s0_ready), SW'((j % 2) == 0));
      check("tie_s1_ready", SW'(s1_ready), SW'((j % 2) == 1));
      @(posedge clk); #1;
      @(negedge clk);
      check("tie_ready_run", SW'({s0_ready, s1_ready}), SW'(0));
      check("tie_rf_round", SW'(rf_round), SW'(11));
      @(negedge clk);
      check("tie_m_valid", SW'(m_valid), SW'(1));
      check("tie_m_id", SW'(m_id), SW'(j % 2));
      check("tie_m_state", m_state, SW'(128'h0B));
      check("tie_ready_done", SW'({s0_ready, s1_ready}), SW'(0));
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      exp_jobs++;
      check("tie_jobs", SW'(job_count), SW'(exp_jobs));
    end
    s0_valid = 1'b0; s1_valid = 1'b0;

    // Reset in the 3rd RUN cycle of a 12-round job discards it
    do_reset();
    s0_valid = 1'b1; s0_state = TOP_LOW; s0_rounds = 4'd12;
    @(posedge clk); #1;
    s0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_rf_round", SW'(rf_round), SW'(2));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", SW'(busy), SW'(0));
    check("abort_m_valid", SW'(m_valid), SW'(0));
    check("abort_jobs", SW'(job_count), SW'(0));
    @(posedge clk); #1;
    do_job(1'b0, TOP_LOW, 4'd1, SW'(128'h08), 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ascon_perm_scheduler.md
Name: ascon_perm_scheduler

Overview:
- Sequences one shared, single-round, combinational ASCON permutation core on behalf of two requesters, for example the encrypt and decrypt engines.
- Arbitrates between the requesters round-robin and captures the granted request's state.
- Iterates the round function N times while driving the correct round index, then returns the permuted state on a valid/ready output channel tagged with the requester ID.
- Sits between the mode engines and the permutation core; the only block allowed to drive the core.

Parameters:
STATE_W, 128, permutation state width in bits.
MAX_ROUNDS, 12, rounds in a full p^a permutation; round indices span 0..MAX_ROUNDS-1.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
s0_valid  in  1  requester 0 has a job.
s0_ready  out  1  requester 0 job accepted this cycle.
s0_state  in  STATE_W  requester 0 input state.
s0_rounds  in  4  requester 0 round count.
s1_valid / s1_ready / s1_state / s1_rounds  same as requester 0, for requester 1.
rf_state_in  out  STATE_W  state presented to the round core.
rf_round  out  4  round index presented to the round core.
rf_state_out  in  STATE_W  combinational core result.
m_valid  out  1  result available.
m_ready  in  1  consumer accepts result.
m_state  out  STATE_W  permuted state.
m_id  out  1  requester that owns the result.
busy  out  1  high in RUN or DONE.
job_count  out  16  completed-job counter.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high.
  - On an rst edge: FSM goes to IDLE.
  - m_valid=0, m_state=0, m_id=0, busy=0, job_count=0, internal state register=0, round counter=0.
  - last_grant=1, so requester 0 wins the first tie.
  - rst overrides every other input on that edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant: if exactly one s*_valid is high, that requester; if both are high, the requester != last_grant.
  - s*_ready is combinational and is 1 only for the granted requester, only in IDLE.
  - On an accept edge (valid&&ready):
    - capture the state into the state register;
    - capture N = s_rounds, clamped so that 0 or >12 becomes 12;
    - start = MAX_ROUNDS-N; cnt=0; m_id=grant; last_grant=grant;
    - go to RUN.
  - Requester inputs are don't-care after the accept edge.
- RUN:
  - rf_state_in = state register; rf_round = start+cnt.
  - Each edge: state <= rf_state_out; cnt++.
  - On the edge that applies round N (cnt==N-1): m_state <= rf_state_out, m_valid <= 1, go to DONE.
  - Both s*_ready = 0.
- DONE:
  - m_valid held high; m_state and m_id stable until m_ready.
  - On m_valid&&m_ready: m_valid <= 0, job_count <= job_count+1 (wraps 0xFFFF->0x0000), go to IDLE.
- Latency and throughput:
  - m_valid is first high in the cycle N edges after the accept edge.
  - One mandatory IDLE cycle between jobs, so throughput is N+2 cycles per job with m_ready held high.
- Outside RUN: rf_round=0 and rf_state_in=state register; the core output is ignored.
- busy = (FSM != IDLE).
- Reset mid-RUN or mid-DONE: the job is discarded, no result is emitted, job_count is unchanged.

Test Plan:
Bench round-core stub: rf_state_out = rotl1(rf_state_in) ^ rf_round, with rf_round zero-extended into the low bits.

1. s0_valid=1, s0_state=0, s0_rounds=1 -> s0_ready=1 for one cycle; rf_round=11; m_valid high 1 cycle after the accept edge; m_state=0x0B; m_id=0; job_count=1 after m_ready.
2. s1_valid, s1_state=0, s1_rounds=2 -> rf_round sequence 10,11; m_state=0x1F; m_id=1; m_valid high 2 cycles after accept.
3. Both valid from reset with rounds=1 -> requester 0 granted first; after completion requester 1 granted on the next tie; then requester 0 again (strict alternation); s1_ready stays 0 while requester 0 is served.
4. s0_rounds=0 and separately s0_rounds=15 -> treated as 12; rf_round steps 0..11; m_valid high 12 cycles after accept.
5. m_ready=0 for 5 cycles in DONE -> m_valid, m_state, m_id stable; both s*_ready=0; job_count increments exactly once when m_ready=1; the next accept is possible 1 cycle later.
6. rst=1 for one edge in the 3rd RUN cycle of a 12-round job -> next cycle busy=0, m_valid=0, job_count unchanged; a following job completes with correct m_state.
